// File: rtl/mips_run_ctrl.sv
// Boot/run sequencer for the single-cycle MIPS core: load program, release core, detect halt, freeze.
// Latency: an accepted word appears on core_we/core_wins the next cycle; core_rst rises 2 cycles after the last word.
// Backpressure: ld_ready is high only in LOAD (registered), so every ld_valid cycle in LOAD is a handshake.
//
// Ports:
//   CLK, RST            clock, asynchronous active-low reset
//   start               one-cycle pulse, begins a session from IDLE or HALT
//   ld_valid/ld_data/ld_last/ld_ready   program word stream
//   core_rst/core_we/core_wins          core control: reset (active-low), imem write
//   core_pc/core_result                 core status observed while running
//   busy/done/timeout/cycles/last_result  session status
module mips_run_ctrl #(
  parameter int unsigned MAX_CYCLES = 1024,
  parameter int unsigned CW         = 16,
  parameter logic [31:0] HALT_PC    = 32'hFFFF_FFFC
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic          ld_valid,
  input  logic [31:0]   ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          core_rst,
  output logic          core_we,
  output logic [31:0]   core_wins,
  input  logic [31:0]   core_pc,
  input  logic [31:0]   core_result,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycles,
  output logic [31:0]   last_result
);

  localparam logic [CW-1:0] CYC_MAX  = CW'(MAX_CYCLES);
  localparam logic [CW-1:0] CYC_LAST = CW'(MAX_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT1,
    S_RUN,
    S_HALT
  } state_t;

  state_t        state_q, state_d;
  logic          we_d;
  logic [31:0]   wins_d;
  logic [CW-1:0] cycles_d;
  logic          timeout_d;
  logic [31:0]   result_d;
  logic [31:0]   prev_pc, prev_pc_d;
  logic          pv, pv_d;
  logic          halt_addr, halt_self, halt_budget;

  // core_pc comes straight from the core's PC register, so it is stable at the edge.
  assign halt_addr   = (core_pc == HALT_PC);
  assign halt_self   = pv && (core_pc == prev_pc);
  // Fires on the last budgeted cycle, so the session sees exactly MAX_CYCLES run cycles.
  assign halt_budget = (cycles == CYC_LAST);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    we_d      = 1'b0;
    wins_d    = core_wins;
    cycles_d  = cycles;
    timeout_d = timeout;
    result_d  = last_result;
    prev_pc_d = prev_pc;
    // pv only survives inside a RUN stretch, so every new run starts without a previous PC.
    pv_d      = 1'b0;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d   = S_LOAD;
          cycles_d  = '0;
          timeout_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (ld_valid && ld_ready) begin
          we_d   = 1'b1;
          wins_d = ld_data;
          if (ld_last) state_d = S_WAIT1;
        end
      end
      S_WAIT1: begin
        // The last word is written during this cycle while the core is still held in reset.
        state_d = S_RUN;
      end
      S_RUN: begin
        prev_pc_d = core_pc;
        pv_d      = 1'b1;
        if (cycles != CYC_MAX) cycles_d = cycles + 1'b1;
        if (halt_addr || halt_self || halt_budget) begin
          state_d   = S_HALT;
          result_d  = core_result;
          // A real halt on the budget cycle is not a timeout.
          timeout_d = halt_budget && !halt_addr && !halt_self;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // All outputs are registered; state-derived ones are computed from the next state.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ld_ready    <= 1'b0;
      core_rst    <= 1'b0;
      core_we     <= 1'b0;
      core_wins   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      cycles      <= '0;
      last_result <= '0;
      prev_pc     <= '0;
      pv          <= 1'b0;
    end else begin
      ld_ready    <= (state_d == S_LOAD);
      core_rst    <= (state_d == S_RUN);
      busy        <= (state_d == S_LOAD) || (state_d == S_WAIT1) || (state_d == S_RUN);
      done        <= (state_d == S_HALT);
      core_we     <= we_d;
      core_wins   <= wins_d;
      cycles      <= cycles_d;
      timeout     <= timeout_d;
      last_result <= result_d;
      prev_pc     <= prev_pc_d;
      pv          <= pv_d;
    end
  end

endmodule
